// File: rtl/uart_tx_buf_if.sv
// Producer-side byte stream into the UART transmit buffer.
// A byte moves on a rising edge where in_valid && in_ready. The producer holds in_data
// stable while in_valid is high, and in_ready never depends on in_valid.
interface uart_tx_buf_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/uart_tx_buf.sv
// FIFO byte buffer that sequences bytes into a UART transmitter with a fixed enable pulse and inter-byte gap.
// Optional WAIT-state timeout is compiled in with `define UART_TX_BUF_TIMEOUT_EN.
module uart_tx_buf #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int EN_HOLD = 4,
  parameter int GAP_CYC = 2
`ifdef UART_TX_BUF_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  uart_tx_buf_if.slave   in_if,
  input  logic           flush,
  output logic [7:0]     uart_data,
  output logic           uart_tx_en,
  input  logic           tx_done,
  output logic [AW:0]    fifo_count,
  output logic           busy,
  output logic           err_timeout,
  output logic [1:0]     dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_e;

  localparam int CW = 16;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      data_q, data_d;
  logic            en_q, en_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      mem_q [DEPTH];
  logic            push, pop;
`ifdef UART_TX_BUF_TIMEOUT_EN
  logic            err_q, err_d;
`endif

  assign in_if.in_ready = !sys_rst && (count_q != (AW+1)'(DEPTH));
  assign push = in_if.in_valid && in_if.in_ready && !flush;
  assign pop  = (state_q == IDLE) && (count_q != '0) && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    state_d  = state_q;
    data_d   = data_q;
    en_d     = en_q;
    cnt_d    = cnt_q;
`ifdef UART_TX_BUF_TIMEOUT_EN
    err_d    = err_q;
`endif

    // Flush empties the queue but leaves an already-launched byte running.
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + (AW+1)'(1);
      else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end

    // cnt is shared: enable hold time in PULSE, timeout in WAIT, gap length in GAP.
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          data_d  = mem_q[rd_ptr_q];
          en_d    = 1'b1;
          cnt_d   = '0;
          state_d = PULSE;
        end
      end
      PULSE: begin
        if (cnt_q == CW'(EN_HOLD - 1)) begin
          en_d    = 1'b0;
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT: begin
        if (tx_done) begin
          cnt_d   = '0;
          state_d = GAP;
        end
`ifdef UART_TX_BUF_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
`endif
      end
      GAP: begin
        if (cnt_q == CW'(GAP_CYC - 1)) state_d = IDLE;
        else                            cnt_d   = cnt_q + CW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= 8'h00;
      en_q     <= 1'b0;
      cnt_q    <= '0;
`ifdef UART_TX_BUF_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      en_q     <= en_d;
      cnt_q    <= cnt_d;
`ifdef UART_TX_BUF_TIMEOUT_EN
      err_q    <= err_d;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_ptr_q] <= in_if.in_data;
  end

  assign uart_data  = data_q;
  assign uart_tx_en = en_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);
  assign dbg_state  = state_q;
`ifdef UART_TX_BUF_TIMEOUT_EN
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: a countdown-style model of the buffer plus a transmitter responder,
// checked every cycle, with hand-computed literal checks on latency, pulse width, gap and byte order.
module tb_uart_tx_buf;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int EN_HOLD = 4;
  localparam int GAP     = 2;
  localparam int TO_CYC  = 100;

  logic          sys_clk;
  logic          sys_rst;
  logic          flush;
  logic [7:0]    uart_data;
  logic          uart_tx_en;
  logic          tx_done;
  logic [AW:0]   fifo_count;
  logic          busy;
  logic          err_timeout;
  logic [1:0]    dbg_state;

  uart_tx_buf_if in_if();

  uart_tx_buf #(
    .DEPTH(DEPTH), .AW(AW), .EN_HOLD(EN_HOLD), .GAP_CYC(GAP)
`ifdef UART_TX_BUF_TIMEOUT_EN
    , .TIMEOUT_CYC(TO_CYC)
`endif
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .in_if(in_if), .flush(flush),
    .uart_data(uart_data), .uart_tx_en(uart_tx_en), .tx_done(tx_done),
    .fifo_count(fifo_count), .busy(busy), .err_timeout(err_timeout), .dbg_state(dbg_state)
  );

  // clock / reset block
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // behavioural model: queue of bytes plus countdowns for the current transmission
  logic [7:0] mq[$];
  logic [7:0] m_data;
  int         en_left, gap_left, wait_cyc;
  bit         waiting, m_err, mdl_on;

  always @(posedge sys_clk) begin
    bit idle, launch, do_push;
    if (sys_rst) begin
      mq.delete();
      m_data = 8'h00; en_left = 0; gap_left = 0; wait_cyc = 0;
      waiting = 1'b0; m_err = 1'b0; mdl_on = 1'b1;
    end else begin
      idle    = (en_left == 0) && !waiting && (gap_left == 0);
      launch  = idle && (mq.size() != 0) && !flush;
      do_push = in_if.in_valid && (mq.size() < DEPTH) && !flush;
      if (en_left > 0) begin
        en_left--;
        if (en_left == 0) begin
          waiting  = 1'b1;
          wait_cyc = 0;
        end
      end else if (waiting) begin
        if (tx_done) begin
          waiting  = 1'b0;
          gap_left = GAP;
        end
`ifdef UART_TX_BUF_TIMEOUT_EN
        else begin
          wait_cyc++;
          if (wait_cyc == TO_CYC) begin
            m_err    = 1'b1;
            waiting  = 1'b0;
            gap_left = GAP;
          end
        end
`endif
      end else if (gap_left > 0) begin
        gap_left--;
      end
      if (flush) mq.delete();
      if (launch) begin
        m_data  = mq.pop_front();
        en_left = EN_HOLD;
      end
      if (do_push) mq.push_back(in_if.in_data);
    end
  end

  // compare process
  always @(negedge sys_clk) begin
    if (mdl_on) begin
      chk("cyc_in_ready",   {31'b0, in_if.in_ready}, {31'b0, (!sys_rst && mq.size() != DEPTH)});
      chk("cyc_fifo_count", 32'(fifo_count), 32'(mq.size()));
      chk("cyc_tx_en",      {31'b0, uart_tx_en}, {31'b0, (en_left > 0)});
      chk("cyc_uart_data",  {24'b0, uart_data}, {24'b0, m_data});
      chk("cyc_busy",       {31'b0, busy}, {31'b0, ((en_left > 0) || waiting || (gap_left > 0) || (mq.size() != 0))});
      chk("cyc_err",        {31'b0, err_timeout}, {31'b0, m_err});
    end
  end

  // transmitter responder: logs each launched byte and pulses tx_done done_dly cycles after the rise
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int done_dly = 0;
  int done_num = 0;
  int rise_cnt = 0;
  bit armed    = 1'b0;
  bit en_prev  = 1'b0;

  always @(negedge sys_clk) begin
    tx_done = 1'b0;
    if (sys_rst) begin
      armed   = 1'b0;
      en_prev = 1'b0;
    end else begin
      if (uart_tx_en && !en_prev) begin
        got_q.push_back(uart_data);
        rise_cnt = 0;
        armed    = 1'b1;
      end else if (armed) begin
        rise_cnt++;
      end
      if (armed && done_dly != 0 && rise_cnt >= done_dly) begin
        tx_done = 1'b1;
        armed   = 1'b0;
        done_num++;
      end
      en_prev = uart_tx_en;
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push_hold(input logic [7:0] b, input int bound);
    bit had;
    in_if.in_valid = 1'b1;
    in_if.in_data  = b;
    for (int i = 0; i < bound; i++) begin
      had = in_if.in_ready;
      cyc();
      if (had) break;
    end
    in_if.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (busy && n < bound) begin
      cyc();
      n++;
    end
    chk("idle_reached", {31'b0, busy}, 32'd0);
  endtask

  task automatic compare_sent(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk({name, "_byte"}, {24'b0, got_q[i]}, {24'b0, exp_q[i]});
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    sys_rst = 1'b1;
    flush = 1'b0;
    in_if.in_valid = 1'b0;
    in_if.in_data  = 8'h00;
    repeat (2) cyc();
    chk("rst_in_ready", {31'b0, in_if.in_ready}, 32'd0);
    chk("rst_count",    32'(fifo_count), 32'd0);
    chk("rst_tx_en",    {31'b0, uart_tx_en}, 32'd0);
    chk("rst_data",     {24'b0, uart_data}, 32'h00);
    chk("rst_busy",     {31'b0, busy}, 32'd0);
    chk("rst_err",      {31'b0, err_timeout}, 32'd0);
    sys_rst = 1'b0;
    cyc();
    chk("rel_in_ready", {31'b0, in_if.in_ready}, 32'd1);

    // single byte: launch latency, pulse width, data, gap to idle
    done_dly = 20;
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'hA5;
    cyc();
    in_if.in_valid = 1'b0;
    chk("t1_count_after_push", 32'(fifo_count), 32'd1);
    chk("t1_en_not_yet",       {31'b0, uart_tx_en}, 32'd0);
    cyc();
    chk("t1_en_rise",   {31'b0, uart_tx_en}, 32'd1);
    chk("t1_data",      {24'b0, uart_data}, 32'hA5);
    chk("t1_count_pop", 32'(fifo_count), 32'd0);
    n = 1;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (uart_tx_en) n++;
      else break;
    end
    chk("t1_en_width", 32'(n), 32'd4);
    for (int i = 0; i < 60 && done_num == 0; i++) cyc();
    chk("t1_done_seen", 32'(done_num), 32'd1);
    n = 1;
    for (int i = 0; i < 20 && busy; i++) begin
      cyc();
      n++;
    end
    chk("t1_busy_drop", 32'(n), 32'd3);
    chk("t1_data_hold", {24'b0, uart_data}, 32'hA5);
    exp_q.push_back(8'hA5);
    compare_sent("t1_sent");

    // fill to full while the first byte waits forever, then refill across a pop
    done_dly = 0;
    for (int i = 0; i < 17; i++) push_hold(8'(i), 5);
    chk("t2_full_count", 32'(fifo_count), 32'd16);
    chk("t2_full_ready", {31'b0, in_if.in_ready}, 32'd0);
    in_if.in_valid = 1'b1;
    in_if.in_data  = 8'h11;
    repeat (3) cyc();
    chk("t2_no_overwrite", 32'(fifo_count), 32'd16);
    done_dly = 5;
    push_hold(8'h11, 60);
    chk("t3_refill_count", 32'(fifo_count), 32'd16);
    wait_idle(1000);
    for (int i = 0; i < 18; i++) exp_q.push_back(8'(i));
    compare_sent("t2_order");

    // flush while the first of three bytes is in its enable pulse
    done_dly = 10;
    push_hold(8'hB0, 5);
    push_hold(8'hB1, 5);
    push_hold(8'hB2, 5);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    chk("t4_flush_count", 32'(fifo_count), 32'd0);
    chk("t4_en_kept",     {31'b0, uart_tx_en}, 32'd1);
    wait_idle(200);
    exp_q.push_back(8'hB0);
    compare_sent("t4_sent");

    // reset while waiting with five bytes queued
    done_dly = 0;
    for (int i = 0; i < 6; i++) push_hold(8'hC0 + 8'(i), 5);
    repeat (4) cyc();
    chk("t5_wait_en",    {31'b0, uart_tx_en}, 32'd0);
    chk("t5_wait_count", 32'(fifo_count), 32'd5);
    sys_rst = 1'b1;
    cyc();
    chk("t5_rst_count", 32'(fifo_count), 32'd0);
    chk("t5_rst_en",    {31'b0, uart_tx_en}, 32'd0);
    chk("t5_rst_data",  {24'b0, uart_data}, 32'h00);
    chk("t5_rst_busy",  {31'b0, busy}, 32'd0);
    chk("t5_rst_ready", {31'b0, in_if.in_ready}, 32'd0);
    sys_rst = 1'b0;
    cyc();
    done_dly = 5;
    push_hold(8'hD7, 5);
    wait_idle(200);
    exp_q.push_back(8'hC0);
    exp_q.push_back(8'hD7);
    compare_sent("t5_sent");

`ifdef UART_TX_BUF_TIMEOUT_EN
    // withheld tx_done times out; then tx_done on the timeout cycle wins
    done_dly = 0;
    push_hold(8'hE1, 5);
    push_hold(8'hE2, 5);
    repeat (110) cyc();
    chk("t6_err_set", {31'b0, err_timeout}, 32'd1);
    done_dly = 5;
    wait_idle(400);
    chk("t6_err_sticky", {31'b0, err_timeout}, 32'd1);
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'hE2);
    compare_sent("t6_sent");
    sys_rst = 1'b1;
    cyc();
    sys_rst = 1'b0;
    cyc();
    done_dly = 103;
    push_hold(8'hF1, 5);
    wait_idle(400);
    chk("t6_err_clear", {31'b0, err_timeout}, 32'd0);
    exp_q.push_back(8'hF1);
    compare_sent("t6b_sent");
`endif

    repeat (2) cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
